// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the fetch/data memory port arbiter.
package mem_arb_pkg;

    // Sequencer states: no grant, memory held, one-cycle response.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Which requester currently owns the memory.
    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } owner_e;

    // Bits needed to hold a count from 0 up to and including max_val.
    function automatic int width_for(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-port memory between instruction fetch
// and load/store. Data wins by default; a streak counter forces a fetch grant
// after MAX_DATA_STREAK consecutive data grants made while fetch was waiting.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W          = 64,
    parameter int DATA_W          = 64,
    parameter int MEM_LAT         = 2,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_ready,
    output logic [31:0]       if_rdata,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall
);

    localparam int CNT_W    = width_for(MEM_LAT);
    localparam int STREAK_W = width_for(MAX_DATA_STREAK);

    state_e              state_q,     state_d;
    owner_e              owner_q,     owner_d;
    logic [STREAK_W-1:0] streak_q,    streak_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic                sel_q,       sel_d;
    logic                mem_en_q,    mem_en_d;
    logic                mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                if_ready_q,  if_ready_d;
    logic                d_ready_q,   d_ready_d;
    logic [31:0]         if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q,   d_rdata_d;

    logic d_req_s;
    logic streak_full_s;
    logic fetch_wins_s;
    logic unused_addr_bits_s;

    assign d_req_s       = d_rd | d_wr;
    assign streak_full_s = (streak_q == STREAK_W'(MAX_DATA_STREAK));
    assign fetch_wins_s  = if_req & (~d_req_s | streak_full_s);
    // Fetch addresses are word aligned; the low byte-offset bits carry no meaning here.
    assign unused_addr_bits_s = &{1'b0, if_addr[1:0]};

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= FETCH;
            streak_q    <= '0;
            cnt_q       <= '0;
            sel_q       <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
            if_rdata_q  <= 32'h0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            streak_q    <= streak_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ready_q  <= if_ready_d;
            d_ready_q   <= d_ready_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    // Next-state logic: grant in IDLE, count latency in ACCESS, pulse ready in RESP.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        streak_d    = streak_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ready_d  = 1'b0;
        d_ready_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (if_req | d_req_s) begin
                    state_d  = ACCESS;
                    cnt_d    = CNT_W'(MEM_LAT - 1);
                    mem_en_d = 1'b1;
                    if (fetch_wins_s) begin
                        owner_d    = FETCH;
                        streak_d   = '0;
                        sel_d      = if_addr[2];
                        mem_addr_d = ADDR_W'({if_addr[31:3], 3'b000});
                        mem_we_d   = 1'b0;
                    end else begin
                        owner_d     = DATA;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        // A simultaneous load and store is carried out as a store.
                        mem_we_d    = d_wr;
                        if (if_req && !streak_full_s) begin
                            streak_d = streak_q + STREAK_W'(1);
                        end else begin
                            streak_d = streak_q;
                        end
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (cnt_q == CNT_W'(0)) begin
                    state_d = RESP;
                    if (owner_q == FETCH) begin
                        if_ready_d = 1'b1;
                        if_rdata_d = sel_q ? mem_rdata[63:32] : mem_rdata[31:0];
                    end else begin
                        d_ready_d = 1'b1;
                        // Stores leave the load data register untouched.
                        if (!mem_we_q) begin
                            d_rdata_d = mem_rdata;
                        end else begin
                            d_rdata_d = d_rdata_q;
                        end
                    end
                end else begin
                    cnt_d    = cnt_q - CNT_W'(1);
                    mem_en_d = 1'b1;
                    mem_we_d = mem_we_q;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign stall     = (if_req | d_req_s) & (state_q != RESP);
    assign if_ready  = if_ready_q;
    assign if_rdata  = if_rdata_q;
    assign d_ready   = d_ready_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a read-data scoreboard.
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        d_rd, d_wr;
    logic [63:0] d_addr, d_wdata;
    logic        d_ready;
    logic [63:0] d_rdata;
    logic        mem_en, mem_we;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        stall;

    int errors = 0;
    int checks = 0;
    logic [63:0] if_q[$];
    logic [63:0] d_q[$];

    mem_port_arbiter #(
        .ADDR_W(64), .DATA_W(64), .MEM_LAT(2), .MAX_DATA_STREAK(4)
    ) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall(stall)
    );

    always #5 clock = ~clock;

    // Memory contents model; poison value whenever the port is not enabled.
    function automatic logic [63:0] mem_fn(input logic [63:0] a);
        if (a == 64'h10) return 64'hAAAA_BBBB_CCCC_DDDD;
        return {a[31:0] ^ 32'h5A5A_0000, a[31:0] ^ 32'h0000_A5A5};
    endfunction

    assign mem_rdata = mem_en ? mem_fn(mem_addr) : 64'hBAD0_BAD0_BAD0_BAD0;

    function automatic logic [63:0] fetch_exp(input logic [31:0] pc);
        logic [63:0] w;
        w = mem_fn({32'h0, pc[31:3], 3'b000});
        return pc[2] ? {32'h0, w[63:32]} : {32'h0, w[31:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Advance until a ready pulse (bounded), collecting memory-port activity.
    task automatic run_until_ready(output int cyc, output bit got_if, output bit got_d,
                                   output int en_cnt, output int we_cnt,
                                   output logic [63:0] first_addr, output logic [63:0] first_wdata,
                                   output bit stall_ok);
        cyc = 0; got_if = 1'b0; got_d = 1'b0; en_cnt = 0; we_cnt = 0;
        first_addr = 64'h0; first_wdata = 64'h0; stall_ok = 1'b1;
        while (!(got_if || got_d) && cyc < 20) begin
            tick();
            cyc++;
            if (mem_en) begin
                if (en_cnt == 0) begin
                    first_addr  = mem_addr;
                    first_wdata = mem_wdata;
                end
                en_cnt++;
                if (mem_we) we_cnt++;
            end
            if (if_ready || d_ready) begin
                got_if = if_ready;
                got_d  = d_ready;
                if (stall) stall_ok = 1'b0;
            end else if (!stall) begin
                stall_ok = 1'b0;
            end
        end
        if (!(got_if || got_d)) check("ready_timeout", 64'h0, 64'h1);
    endtask

    // Pop the scoreboard entry for whichever port pulsed ready.
    task automatic score(input bit got_if, input bit got_d);
        logic [63:0] e;
        if (got_if) begin
            if (if_q.size() == 0) check("if_unexpected", 64'h1, 64'h0);
            else begin
                e = if_q.pop_front();
                check("if_rdata", {32'h0, if_rdata}, e);
            end
        end
        if (got_d) begin
            if (d_q.size() == 0) check("d_unexpected", 64'h1, 64'h0);
            else begin
                e = d_q.pop_front();
                check("d_rdata", d_rdata, e);
            end
        end
    endtask

    initial begin
        int cyc, en_cnt, we_cnt, pulses;
        bit got_if, got_d, stall_ok;
        logic [63:0] fa, fw, d_model;

        reset = 1'b1; if_req = 1'b0; if_addr = 32'h0;
        d_rd = 1'b0; d_wr = 1'b0; d_addr = 64'h0; d_wdata = 64'h0;
        tick(); tick(); tick();
        check("rst_mem_en", {63'h0, mem_en}, 64'h0);
        check("rst_mem_we", {63'h0, mem_we}, 64'h0);
        check("rst_ready", {62'h0, if_ready, d_ready}, 64'h0);
        check("rst_mem_addr", mem_addr, 64'h0);
        check("rst_rdata", {32'h0, if_rdata} | d_rdata, 64'h0);
        check("rst_stall", {63'h0, stall}, 64'h0);
        reset = 1'b0;
        tick();

        // Single fetch from PC 0x14 (upper word).
        if_req = 1'b1; if_addr = 32'h14;
        if_q.push_back(64'h0000_0000_AAAA_BBBB);
        run_until_ready(cyc, got_if, got_d, en_cnt, we_cnt, fa, fw, stall_ok);
        check("fetch_latency", 64'(cyc), 64'd3);
        check("fetch_is_if", {62'h0, got_if, got_d}, 64'h2);
        check("fetch_mem_addr", fa, 64'h10);
        check("fetch_en_cycles", 64'(en_cnt), 64'd2);
        check("fetch_we", 64'(we_cnt), 64'd0);
        check("fetch_stall", {63'h0, stall_ok}, 64'h1);
        score(got_if, got_d);
        if_req = 1'b0;
        tick();
        check("fetch_pulse_once", {62'h0, if_ready, d_ready}, 64'h0);

        // Load to set up a known d_rdata.
        d_rd = 1'b1; d_addr = 64'h80;
        d_model = mem_fn(64'h80);
        d_q.push_back(d_model);
        run_until_ready(cyc, got_if, got_d, en_cnt, we_cnt, fa, fw, stall_ok);
        check("load_is_d", {62'h0, got_if, got_d}, 64'h1);
        score(got_if, got_d);
        d_rd = 1'b0;
        tick();

        // Store: two write cycles, d_rdata unchanged.
        d_wr = 1'b1; d_addr = 64'h40; d_wdata = 64'h1234;
        d_q.push_back(d_model);
        run_until_ready(cyc, got_if, got_d, en_cnt, we_cnt, fa, fw, stall_ok);
        check("store_latency", 64'(cyc), 64'd3);
        check("store_en_cycles", 64'(en_cnt), 64'd2);
        check("store_we_cycles", 64'(we_cnt), 64'd2);
        check("store_mem_addr", fa, 64'h40);
        check("store_mem_wdata", fw, 64'h1234);
        score(got_if, got_d);
        d_wr = 1'b0;
        tick();
        check("store_pulse_once", {62'h0, if_ready, d_ready}, 64'h0);
        check("store_we_off", {62'h0, mem_en, mem_we}, 64'h0);

        // Collision: data first, fetch 4 cycles after d_ready.
        if_req = 1'b1; if_addr = 32'h20; d_rd = 1'b1; d_addr = 64'h88;
        d_model = mem_fn(64'h88);
        d_q.push_back(d_model);
        if_q.push_back(fetch_exp(32'h20));
        run_until_ready(cyc, got_if, got_d, en_cnt, we_cnt, fa, fw, stall_ok);
        check("coll_first_d", {62'h0, got_if, got_d}, 64'h1);
        score(got_if, got_d);
        d_rd = 1'b0;
        run_until_ready(cyc, got_if, got_d, en_cnt, we_cnt, fa, fw, stall_ok);
        check("coll_then_if", {62'h0, got_if, got_d}, 64'h2);
        check("coll_if_gap", 64'(cyc), 64'd4);
        score(got_if, got_d);
        if_req = 1'b0;
        tick();

        // Fairness: four data grants, one fetch, then the streak starts over.
        if_req = 1'b1; if_addr = 32'h30; d_rd = 1'b1; d_addr = 64'h100;
        if_q.push_back(fetch_exp(32'h30));
        d_model = mem_fn(64'h100);
        d_q.push_back(d_model);
        for (int i = 0; i < 10; i++) begin
            run_until_ready(cyc, got_if, got_d, en_cnt, we_cnt, fa, fw, stall_ok);
            check($sformatf("fair_owner_%0d", i), {62'h0, got_if, got_d},
                  (i % 5 == 4) ? 64'h2 : 64'h1);
            check($sformatf("fair_lat_%0d", i), 64'(cyc), (i == 0) ? 64'd3 : 64'd4);
            score(got_if, got_d);
            if (got_d) begin
                d_addr = d_addr + 64'h8;
                d_model = mem_fn(d_addr);
                d_q.push_back(d_model);
            end
            if (got_if && i < 9) begin
                if_addr = if_addr + 32'h4;
                if_q.push_back(fetch_exp(if_addr));
            end
        end
        if_req = 1'b0; d_rd = 1'b0;
        d_q.delete();
        tick();

        // Reset in the first ACCESS cycle of a store aborts it.
        d_wr = 1'b1; d_addr = 64'h48; d_wdata = 64'hBEEF;
        tick();
        check("abort_access_we", {62'h0, mem_en, mem_we}, 64'h3);
        reset = 1'b1;
        tick();
        reset = 1'b0; d_wr = 1'b0;
        check("abort_en_we", {62'h0, mem_en, mem_we}, 64'h0);
        check("abort_ready", {62'h0, if_ready, d_ready}, 64'h0);
        check("abort_mem_addr", mem_addr, 64'h0);
        check("abort_mem_wdata", mem_wdata, 64'h0);
        check("abort_if_rdata", {32'h0, if_rdata}, 64'h0);
        check("abort_d_rdata", d_rdata, 64'h0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (d_ready || if_ready || mem_en) pulses++;
        end
        check("abort_quiet", 64'(pulses), 64'd0);

        // Load and store together behave as a store.
        d_rd = 1'b1; d_wr = 1'b1; d_addr = 64'h50; d_wdata = 64'h77;
        d_q.push_back(64'h0);
        run_until_ready(cyc, got_if, got_d, en_cnt, we_cnt, fa, fw, stall_ok);
        check("rdwr_we_cycles", 64'(we_cnt), 64'd2);
        check("rdwr_wdata", fw, 64'h77);
        score(got_if, got_d);
        d_rd = 1'b0; d_wr = 1'b0;
        tick();

        check("if_q_empty", 64'(if_q.size()), 64'd0);
        check("d_q_empty", 64'(d_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
